// File: rtl/serdes_pkg.sv
// Shared types and constants for the serial word alignment path.
package serdes_pkg;

    // Alignment state: searching, confirming frame spacing, or aligned.
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_t;

    // Default frame alignment pattern.
    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'h7C;

    // Larger of two counts, used to size the shared hit/miss counters.
    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/sync_detector.sv
// Serial-to-parallel shift window with a registered sync pattern compare.
// The oldest bit of the window sits in bit 0, so a word sent LSB first
// appears in natural bit order once its last bit has been shifted in.
module sync_detector
    import serdes_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  SYNC_WORD = WIDTH'(DEFAULT_SYNC_WORD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_bit,
    output logic [WIDTH-1:0] window,
    output logic             match
);

    logic [WIDTH-1:0] window_r;
    logic [WIDTH-1:0] window_next_s;
    logic             match_r;

    // Next window value: newest bit enters at the MSB.
    always_comb begin
        window_next_s = {serial_bit, window_r[WIDTH-1:1]};
    end

    // Shift the window and register whether its new contents equal the pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_r <= '0;
            match_r  <= 1'b0;
        end else begin
            window_r <= window_next_s;
            match_r  <= (window_next_s == SYNC_WORD);
        end
    end

    assign window = window_r;
    assign match  = match_r;

endmodule

// File: rtl/serial_word_aligner.sv
// Frame aligner: hunts for the sync pattern, confirms it recurs with the
// frame period, then emits the data words of each frame as parallel words.
// A word boundary is acted on one clock after its last bit is sampled.
module serial_word_aligner
    import serdes_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(DEFAULT_SYNC_WORD),
    parameter int unsigned      FRAME_LEN  = 16,
    parameter int unsigned      LOCK_COUNT = 3,
    parameter int unsigned      MISS_LIMIT = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SERIAL_IN,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             PAR_VALID,
    output logic             LOCKED,
    output logic             SYNC_ERR
);

    localparam int unsigned BIT_W  = $clog2(WIDTH);
    localparam int unsigned WORD_W = $clog2(FRAME_LEN);
    localparam int unsigned CNT_W  = $clog2(max_of(LOCK_COUNT, MISS_LIMIT) + 1);

    logic [WIDTH-1:0]  window_s;
    logic              match_s;

    align_state_t      state_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [WORD_W-1:0] word_cnt_r;
    logic [CNT_W-1:0]  hit_cnt_r;
    logic [CNT_W-1:0]  miss_cnt_r;
    logic [WIDTH-1:0]  par_out_r;
    logic              par_valid_r;
    logic              locked_r;
    logic              sync_err_r;

    logic              boundary_s;
    logic              sync_slot_s;
    logic [BIT_W-1:0]  bit_cnt_next_s;
    logic [WORD_W-1:0] word_cnt_next_s;
    logic [CNT_W-1:0]  hit_inc_s;
    logic [CNT_W-1:0]  miss_inc_s;

    sync_detector #(
        .WIDTH     (WIDTH),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_detector (
        .clk        (CLK),
        .rst_n      (RESET),
        .serial_bit (SERIAL_IN),
        .window     (window_s),
        .match      (match_s)
    );

    // Boundary detection and next counter values; word_cnt names the slot in the window.
    always_comb begin
        boundary_s      = 1'b0;
        bit_cnt_next_s  = '0;
        word_cnt_next_s = '0;
        if (bit_cnt_r == BIT_W'(WIDTH - 1)) begin
            boundary_s     = 1'b1;
            bit_cnt_next_s = '0;
        end else begin
            boundary_s     = 1'b0;
            bit_cnt_next_s = bit_cnt_r + BIT_W'(1);
        end
        if (word_cnt_r == WORD_W'(FRAME_LEN - 1)) begin
            word_cnt_next_s = '0;
        end else begin
            word_cnt_next_s = word_cnt_r + WORD_W'(1);
        end
        sync_slot_s = (word_cnt_r == '0);
        hit_inc_s   = hit_cnt_r + CNT_W'(1);
        miss_inc_s  = miss_cnt_r + CNT_W'(1);
    end

    // Alignment FSM with its counters and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r     <= ST_HUNT;
            bit_cnt_r   <= '0;
            word_cnt_r  <= '0;
            hit_cnt_r   <= '0;
            miss_cnt_r  <= '0;
            par_out_r   <= '0;
            par_valid_r <= 1'b0;
            locked_r    <= 1'b0;
            sync_err_r  <= 1'b0;
        end else begin
            par_valid_r <= 1'b0;
            sync_err_r  <= 1'b0;
            case (state_r)
                ST_HUNT: begin
                    bit_cnt_r  <= '0;
                    miss_cnt_r <= '0;
                    if (match_s) begin
                        // The window holds slot 0; the next word is slot 1.
                        state_r    <= ST_VERIFY;
                        word_cnt_r <= WORD_W'(1);
                        hit_cnt_r  <= CNT_W'(1);
                    end else begin
                        word_cnt_r <= '0;
                        hit_cnt_r  <= '0;
                    end
                end
                ST_VERIFY: begin
                    bit_cnt_r <= bit_cnt_next_s;
                    if (boundary_s) begin
                        word_cnt_r <= word_cnt_next_s;
                        if (sync_slot_s) begin
                            if (match_s) begin
                                hit_cnt_r <= hit_inc_s;
                                if (hit_inc_s == CNT_W'(LOCK_COUNT)) begin
                                    state_r    <= ST_LOCKED;
                                    locked_r   <= 1'b1;
                                    miss_cnt_r <= '0;
                                end else begin
                                    state_r <= ST_VERIFY;
                                end
                            end else begin
                                state_r    <= ST_HUNT;
                                bit_cnt_r  <= '0;
                                word_cnt_r <= '0;
                                hit_cnt_r  <= '0;
                            end
                        end else begin
                            state_r <= ST_VERIFY;
                        end
                    end else begin
                        state_r <= ST_VERIFY;
                    end
                end
                ST_LOCKED: begin
                    bit_cnt_r <= bit_cnt_next_s;
                    if (boundary_s) begin
                        word_cnt_r <= word_cnt_next_s;
                        if (!sync_slot_s) begin
                            par_out_r   <= window_s;
                            par_valid_r <= 1'b1;
                        end else if (match_s) begin
                            miss_cnt_r <= '0;
                        end else begin
                            sync_err_r <= 1'b1;
                            if (miss_inc_s == CNT_W'(MISS_LIMIT)) begin
                                // Lock lost: restart the search from scratch.
                                state_r    <= ST_HUNT;
                                locked_r   <= 1'b0;
                                bit_cnt_r  <= '0;
                                word_cnt_r <= '0;
                                hit_cnt_r  <= '0;
                                miss_cnt_r <= '0;
                            end else begin
                                miss_cnt_r <= miss_inc_s;
                            end
                        end
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r    <= ST_HUNT;
                    locked_r   <= 1'b0;
                    bit_cnt_r  <= '0;
                    word_cnt_r <= '0;
                    hit_cnt_r  <= '0;
                    miss_cnt_r <= '0;
                end
            endcase
        end
    end

    assign PAR_OUT   = par_out_r;
    assign PAR_VALID = par_valid_r;
    assign LOCKED    = locked_r;
    assign SYNC_ERR  = sync_err_r;

endmodule

// File: tb/tb_serial_word_aligner.sv
// Bench for serial_word_aligner: directed frame streams, a frame-level
// reference model compared on every clock, plus hand-computed timing pins.
module tb_serial_word_aligner;

    localparam logic [7:0] SYNC = 8'h7C;
    localparam logic [7:0] BAD  = 8'h7D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_in = 1'b0;
    logic [7:0] par_out;
    logic       par_valid;
    logic       locked;
    logic       sync_err;

    serial_word_aligner #(
        .WIDTH      (8),
        .SYNC_WORD  (8'h7C),
        .FRAME_LEN  (16),
        .LOCK_COUNT (3),
        .MISS_LIMIT (2)
    ) dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .SERIAL_IN (serial_in),
        .PAR_OUT   (par_out),
        .PAR_VALID (par_valid),
        .LOCKED    (locked),
        .SYNC_ERR  (sync_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: every received bit, plus the schedule of word boundaries
    // expressed as absolute edge numbers counted from reset release.
    logic mq[$];
    int   m_n, m_next_bnd, m_slot, m_hit, m_miss, m_state; // 0 hunt, 1 verify, 2 locked
    logic [7:0] m_po;
    logic m_pv, m_err;

    // Observed-event bookkeeping (actual values only).
    int   err_cnt, valid_cnt, unlocked_cyc, locked_cyc, rise_n, fall_n;
    logic prev_locked;
    int   pv_n[$];
    logic [7:0] pv_val[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_n - 1);
        end
    endtask

    // Last WIDTH received bits, oldest in bit 0, zero where nothing was received yet.
    function automatic logic [7:0] last_word();
        logic [7:0] w;
        int idx;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            idx = mq.size() - 8 + i;
            if (idx >= 0) w[i] = mq[idx];
        end
        return w;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_n = 0; m_next_bnd = -1; m_slot = 0; m_hit = 0; m_miss = 0; m_state = 0;
        m_po = 8'h00; m_pv = 1'b0; m_err = 1'b0;
        prev_locked = 1'b0;
        pv_n.delete(); pv_val.delete();
    endtask

    task automatic clear_counts();
        err_cnt = 0; valid_cnt = 0; unlocked_cyc = 0; locked_cyc = 0;
        rise_n = -1; fall_n = -1;
    endtask

    // Expected outputs after edge m_n, given the bit sampled on it.
    task automatic model_edge(input logic b);
        logic [7:0] w;
        int s;
        m_pv = 1'b0;
        m_err = 1'b0;
        w = last_word();
        if (m_state == 0) begin
            if (w == SYNC) begin
                m_state = 1; m_next_bnd = m_n + 8; m_slot = 1; m_hit = 1; m_miss = 0;
            end
        end else if (m_n == m_next_bnd) begin
            s = m_slot;
            m_slot = (m_slot + 1) % 16;
            m_next_bnd = m_next_bnd + 8;
            if (s == 0) begin
                if (m_state == 1) begin
                    if (w == SYNC) begin
                        m_hit++;
                        if (m_hit == 3) begin m_state = 2; m_miss = 0; end
                    end else begin
                        m_state = 0;
                    end
                end else begin
                    if (w == SYNC) begin
                        m_miss = 0;
                    end else begin
                        m_err = 1'b1;
                        m_miss++;
                        if (m_miss == 2) m_state = 0;
                    end
                end
            end else if (m_state == 2) begin
                m_po = w;
                m_pv = 1'b1;
            end
        end
        mq.push_back(b);
        m_n++;
    endtask

    // One bit time: drive, clock, update model, compare on the falling edge.
    task automatic step(input logic b);
        int cur;
        serial_in = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        cur = m_n - 1;
        check("cyc_par_valid", 32'(par_valid), 32'(m_pv));
        check("cyc_sync_err",  32'(sync_err),  32'(m_err));
        check("cyc_locked",    32'(locked),    32'(m_state == 2));
        check("cyc_par_out",   32'(par_out),   32'(m_po));
        if (par_valid) begin
            valid_cnt++;
            pv_n.push_back(cur);
            pv_val.push_back(par_out);
        end
        if (sync_err) err_cnt++;
        if (locked) locked_cyc++; else unlocked_cyc++;
        if (locked && !prev_locked) rise_n = cur;
        if (!locked && prev_locked) fall_n = cur;
        prev_locked = locked;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) step(w[i]);
    endtask

    task automatic send_frame(input logic [7:0] s);
        send_word(s);
        for (int k = 0; k < 15; k++) send_word(8'(k));
    endtask

    // Good frame whose slots 3/4 (C0, 07) contain the sync bit pattern straddling a boundary.
    task automatic send_frame_straddle();
        send_word(SYNC);
        for (int k = 1; k < 16; k++) begin
            if (k == 3) send_word(8'hC0);
            else if (k == 4) send_word(8'h07);
            else send_word(8'(k - 1));
        end
    endtask

    // Assert reset between clock edges, check outputs clear at once, release on a falling edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_par_out",   32'(par_out),   32'h0);
        check("rst_par_valid", 32'(par_valid), 32'h0);
        check("rst_locked",    32'(locked),    32'h0);
        check("rst_sync_err",  32'(sync_err),  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Slot k (1..15) of the frame whose slot-1 pulse lands on edge base carries k-1, 8 edges apart.
    task automatic check_frame_pulses(input string tag, input int base);
        int cnt;
        cnt = 0;
        for (int i = 0; i < pv_n.size(); i++) begin
            if (pv_n[i] >= base - 4 && pv_n[i] <= base + 8 * 14 + 4) begin
                cnt++;
                check({tag, "_spacing"}, 32'((pv_n[i] - base) % 8), 32'h0);
                check({tag, "_value"}, 32'(pv_val[i]), 32'((pv_n[i] - base) / 8));
            end
        end
        check({tag, "_count"}, 32'(cnt), 32'd15);
    endtask

    initial begin
        model_reset();
        clear_counts();
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_par_out", 32'(par_out),   32'h0);
        check("reset_valid",   32'(par_valid), 32'h0);
        check("reset_locked",  32'(locked),    32'h0);
        check("reset_err",     32'(sync_err),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // A: aligned stream. Third sync (word 32) completes on edge 263, acted on at 264.
        clear_counts();
        repeat (5) send_frame(SYNC);
        check("A_lock_edge", 32'(rise_n), 32'd264);
        check_frame_pulses("A_frame4", 400);

        // B: same stream behind three stray bits; everything shifts by 3 edges.
        do_reset();
        clear_counts();
        step(1'b1); step(1'b0); step(1'b1);
        repeat (5) send_frame(SYNC);
        check("B_lock_edge", 32'(rise_n), 32'd267);
        check_frame_pulses("B_frame4", 403);

        // C: isolated bad syncs separated by a good one never drop lock.
        clear_counts();
        send_frame(BAD);
        send_frame_straddle();
        send_frame(BAD);
        send_frame(SYNC);
        check("C_sync_err_count", 32'(err_cnt), 32'd2);
        check("C_unlocked_cycles", 32'(unlocked_cyc), 32'd0);

        // D: two bad syncs in a row. Second bad sync is word 160: edge 3+1280+8.
        clear_counts();
        send_frame(BAD);
        send_frame(BAD);
        check("D_sync_err_count", 32'(err_cnt), 32'd2);
        check("D_fall_edge", 32'(fall_n), 32'd1291);
        check("D_locked_after", 32'(locked), 32'h0);
        clear_counts();
        send_frame(SYNC);
        send_frame(SYNC);
        check("D_silent_valid", 32'(valid_cnt), 32'd0);
        check("D_not_yet_locked", 32'(locked), 32'h0);
        send_frame(SYNC);
        check("D_relocked", 32'(locked), 32'h1);
        // Slots 1..14 land inside the frame; slot 15 falls on the next frame's first bit.
        check("D_relock_valid", 32'(valid_cnt), 32'd14);

        // E: sync pattern in data slot 5 during hunt must not lead to lock.
        do_reset();
        clear_counts();
        repeat (5) send_word(8'h00);
        send_word(SYNC);
        repeat (30) send_word(8'h00);
        check("E_never_locked", 32'(locked_cyc), 32'd0);

        // F: reset mid-frame while locked, then a full relock from scratch.
        clear_counts();
        repeat (3) send_frame(SYNC);
        send_word(SYNC);
        for (int k = 0; k < 4; k++) send_word(8'(k));
        check("F_locked_before", 32'(locked), 32'h1);
        do_reset();
        clear_counts();
        repeat (2) send_frame(SYNC);
        check("F_unlocked_2frames", 32'(locked), 32'h0);
        send_frame(SYNC);
        check("F_lock_edge", 32'(rise_n), 32'd264);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
